// File: rtl/pmod_led_pkg.sv
// Shared types and constants for the UART-fed LED pixel path.
package pmod_led_pkg;
  localparam int PIXEL_W         = 24;
  localparam int BYTES_PER_PIXEL = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with input synchroniser and idle-gap detector.
module uart_rx_byte
  import pmod_led_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int GAP_BITS     = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       framing_err,
  output logic       gap
);
  localparam int CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);

  logic rx_p0, rx_p1, rx_s;
  rx_state_e state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift, shift_n;
  logic done_n, ferr_n, gap_run;
  logic [GAP_W-1:0] gap_cnt;

  // stage p0/p1: two-flop synchroniser, idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end
  assign rx_s = rx_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      byte_valid  <= done_n;
      framing_err <= ferr_n;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_n;
    if (done_n) byte_data <= shift;
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    done_n    = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          shift_n   = {rx_s, shift[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Gap counter saturates so one long idle period yields a single pulse.
  assign gap_run = (state == IDLE) && rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt <= '0;
      gap     <= 1'b0;
    end else begin
      gap <= gap_run && (gap_cnt == GAP_W'(GAP_LIMIT - 1));
      if (!gap_run) gap_cnt <= '0;
      else if (gap_cnt != GAP_W'(GAP_LIMIT)) gap_cnt <= gap_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/uart_pixel_rx.sv
// UART byte stream to 24-bit pixel words, buffered in a small FIFO with valid/ready output.
module uart_pixel_rx
  import pmod_led_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_BITS   = 20
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          RX,
  output logic [PIXEL_W-1:0]            pixel_data,
  output logic                          pixel_valid,
  input  logic                          pixel_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_gap,
  output logic                          framing_err,
  output logic                          overflow
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int LVL_W        = PTR_W + 1;

  logic [7:0] rx_byte;
  logic rx_byte_valid;
  logic [1:0] byte_idx;
  logic [15:0] pix_hi;
  logic [PIXEL_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic push_req, push, pop, full;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .GAP_BITS    (GAP_BITS)
  ) u_rx (
    .clk        (CLK),
    .rst        (RST),
    .rx         (RX),
    .byte_data  (rx_byte),
    .byte_valid (rx_byte_valid),
    .framing_err(framing_err),
    .gap        (frame_gap)
  );

  assign push_req = rx_byte_valid && (byte_idx == 2'(BYTES_PER_PIXEL - 1));
  assign pop      = pixel_valid && pixel_ready;
  assign full     = (level == LVL_W'(FIFO_DEPTH));
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign push     = push_req && (!full || pop);

  always_ff @(posedge CLK) begin
    if (RST) begin
      byte_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_req && full && !pop;
      if (framing_err || frame_gap) byte_idx <= '0;
      else if (rx_byte_valid) byte_idx <= push_req ? 2'd0 : byte_idx + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (rx_byte_valid && byte_idx == 2'd0) pix_hi[15:8] <= rx_byte;
    if (rx_byte_valid && byte_idx == 2'd1) pix_hi[7:0]  <= rx_byte;
    if (push) mem[wr_ptr] <= {pix_hi, rx_byte};
  end

  assign pixel_valid = (level != '0);
  assign pixel_data  = pixel_valid ? mem[rd_ptr] : '0;
  assign fifo_level  = level;
endmodule

// File: tb/tb_uart_pixel_rx.sv
// Self-checking bench for uart_pixel_rx: serial stimulus, queue-based pixel model.
module tb_uart_pixel_rx;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RX;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [2:0]  fifo_level;
  logic        frame_gap, framing_err, overflow;

  int n_cmp = 0;
  int n_err = 0;
  int n_ovf, n_ferr, n_gap;
  bit rand_rdy = 1'b0;
  logic [23:0] acc_q[$];
  logic [23:0] exp_q[$];

  uart_pixel_rx #(
    .CLK_HZ    (1000000),
    .BAUD      (62500),
    .FIFO_DEPTH(DEPTH),
    .GAP_BITS  (20)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX         (RX),
    .pixel_data (pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .fifo_level (fifo_level),
    .frame_gap  (frame_gap),
    .framing_err(framing_err),
    .overflow   (overflow)
  );

  always #5 CLK = ~CLK;

  // Observe at the falling edge; inputs only change 1 time unit after a rising edge.
  always @(negedge CLK) begin
    if (!RST) begin
      if (pixel_valid && pixel_ready) acc_q.push_back(pixel_data);
      if (overflow) n_ovf++;
      if (framing_err) n_ferr++;
      if (frame_gap) n_gap++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      if (rand_rdy) pixel_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic clear_mon();
    acc_q.delete();
    exp_q.delete();
    n_ovf = 0;
    n_ferr = 0;
    n_gap = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(CPB);
    end
    RX = stop_bit;
    tick(CPB);
    RX = 1'b1;
  endtask

  task automatic send_pixel(input logic [23:0] p);
    send_byte(p[23:16], 1'b1);
    send_byte(p[15:8], 1'b1);
    send_byte(p[7:0], 1'b1);
  endtask

  function automatic logic [23:0] pack(input int b0, input int b1, input int b2);
    return 24'(b0 * 65536 + b1 * 256 + b2);
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    RX = 1'b1;
    pixel_ready = 1'b0;
    tick(4);
    n_cmp++; if (pixel_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", pixel_valid); end
    n_cmp++; if (pixel_data !== 24'h0) begin n_err++; $display("FAIL reset_data: got %h want 000000", pixel_data); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_cmp++; if ({frame_gap, framing_err, overflow} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b want 000", {frame_gap, framing_err, overflow}); end
    RST = 1'b0;
    tick(4);
  endtask

  task automatic test_single_pixel();
    clear_mon();
    pixel_ready = 1'b1;
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    tick(4);
    n_cmp++; if (acc_q.size() != 1) begin n_err++; $display("FAIL single_count: got %0d want 1", acc_q.size()); end
    else begin
      n_cmp++; if (acc_q[0] !== pack(8'h12, 8'h34, 8'h56)) begin n_err++; $display("FAIL single_data: got %h want 123456", acc_q[0]); end
    end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL single_level: got %0d want 0", fifo_level); end
    pixel_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [23:0] sent[5];
    clear_mon();
    pixel_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sent[i] = 24'($urandom);
      send_pixel(sent[i]);
      if (exp_q.size() < DEPTH) exp_q.push_back(sent[i]);
    end
    tick(4);
    n_cmp++; if (fifo_level !== 3'(exp_q.size())) begin n_err++; $display("FAIL ovf_level: got %0d want %0d", fifo_level, exp_q.size()); end
    n_cmp++; if (n_ovf != 5 - DEPTH) begin n_err++; $display("FAIL ovf_pulses: got %0d want %0d", n_ovf, 5 - DEPTH); end
    n_cmp++; if (pixel_data !== exp_q[0]) begin n_err++; $display("FAIL ovf_head: got %h want %h", pixel_data, exp_q[0]); end
    pixel_ready = 1'b1;
    tick(8);
    pixel_ready = 1'b0;
    n_cmp++; if (acc_q.size() != exp_q.size()) begin n_err++; $display("FAIL ovf_drain_count: got %0d want %0d", acc_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++; if (acc_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_drain_%0d: got %h want %h", i, acc_q[i], exp_q[i]); end
      end
    end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL ovf_empty: got %0d want 0", fifo_level); end
  endtask

  task automatic test_framing();
    clear_mon();
    pixel_ready = 1'b1;
    send_byte(8'h99, 1'b1);
    send_byte(8'hAA, 1'b0);
    tick(2 * CPB);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    tick(4);
    n_cmp++; if (n_ferr != 1) begin n_err++; $display("FAIL ferr_pulses: got %0d want 1", n_ferr); end
    n_cmp++; if (acc_q.size() != 1) begin n_err++; $display("FAIL ferr_count: got %0d want 1", acc_q.size()); end
    else begin
      n_cmp++; if (acc_q[0] !== pack(1, 2, 3)) begin n_err++; $display("FAIL ferr_data: got %h want 010203", acc_q[0]); end
    end
    pixel_ready = 1'b0;
  endtask

  task automatic test_gap();
    pixel_ready = 1'b1;
    tick(25 * CPB);
    clear_mon();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    tick(25 * CPB);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    tick(4);
    n_cmp++; if (n_gap != 1) begin n_err++; $display("FAIL gap_pulses: got %0d want 1", n_gap); end
    n_cmp++; if (acc_q.size() != 1) begin n_err++; $display("FAIL gap_count: got %0d want 1", acc_q.size()); end
    else begin
      n_cmp++; if (acc_q[0] !== pack(8'h33, 8'h44, 8'h55)) begin n_err++; $display("FAIL gap_data: got %h want 334455", acc_q[0]); end
    end
    pixel_ready = 1'b0;
  endtask

  task automatic test_glitch_and_reset();
    clear_mon();
    pixel_ready = 1'b0;
    RX = 1'b0;
    tick(5);
    RX = 1'b1;
    tick(2 * CPB);
    n_cmp++; if (n_ferr != 0) begin n_err++; $display("FAIL glitch_err: got %0d want 0", n_ferr); end
    send_pixel(24'hA1B2C3);
    tick(4);
    n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL glitch_level: got %0d want 1", fifo_level); end
    n_cmp++; if (pixel_data !== 24'hA1B2C3) begin n_err++; $display("FAIL glitch_data: got %h want a1b2c3", pixel_data); end
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    RX = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      RX = 1'($urandom_range(0, 1));
      tick(CPB);
    end
    RST = 1'b1;
    RX = 1'b1;
    tick(2);
    n_cmp++; if ({pixel_valid, fifo_level, frame_gap, framing_err, overflow} !== 7'd0) begin n_err++; $display("FAIL rst_mid_ctrl: got %b want 0000000", {pixel_valid, fifo_level, frame_gap, framing_err, overflow}); end
    n_cmp++; if (pixel_data !== 24'h0) begin n_err++; $display("FAIL rst_mid_data: got %h want 000000", pixel_data); end
    RST = 1'b0;
    tick(12 * CPB);
    clear_mon();
    pixel_ready = 1'b1;
    send_pixel(24'h5A6B7C);
    tick(4);
    n_cmp++; if (acc_q.size() != 1) begin n_err++; $display("FAIL rst_after_count: got %0d want 1", acc_q.size()); end
    else begin
      n_cmp++; if (acc_q[0] !== 24'h5A6B7C) begin n_err++; $display("FAIL rst_after_data: got %h want 5a6b7c", acc_q[0]); end
    end
    n_cmp++; if (n_ferr + n_ovf != 0) begin n_err++; $display("FAIL rst_after_pulses: got %0d want 0", n_ferr + n_ovf); end
    pixel_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [23:0] p;
    bit found;
    clear_mon();
    pixel_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) exp_q.push_back(24'($urandom));
    for (int i = 0; i < DEPTH; i++) send_pixel(exp_q[i]);
    tick(4);
    n_cmp++; if (fifo_level !== 3'(DEPTH)) begin n_err++; $display("FAIL pp_full_level: got %0d want %0d", fifo_level, DEPTH); end
    p = exp_q[DEPTH];
    send_byte(p[23:16], 1'b1);
    send_byte(p[15:8], 1'b1);
    RX = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      RX = p[i];
      tick(CPB);
    end
    RX = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2 * CPB && !found; i++) begin
      if (dut.rx_byte_valid) begin
        pixel_ready = 1'b1;
        tick(1);
        pixel_ready = 1'b0;
        found = 1'b1;
      end else begin
        tick(1);
      end
    end
    tick(CPB);
    n_cmp++; if (!found) begin n_err++; $display("FAIL pp_byte_timeout: got 0 want 1"); end
    n_cmp++; if (n_ovf != 0) begin n_err++; $display("FAIL pp_overflow: got %0d want 0", n_ovf); end
    n_cmp++; if (fifo_level !== 3'(DEPTH)) begin n_err++; $display("FAIL pp_level: got %0d want %0d", fifo_level, DEPTH); end
    pixel_ready = 1'b1;
    tick(8);
    pixel_ready = 1'b0;
    n_cmp++; if (acc_q.size() != exp_q.size()) begin n_err++; $display("FAIL pp_count: got %0d want %0d", acc_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++; if (acc_q[i] !== exp_q[i]) begin n_err++; $display("FAIL pp_data_%0d: got %h want %h", i, acc_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_random_stream();
    int b[12];
    clear_mon();
    rand_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b[i] = int'($urandom_range(0, 255));
      send_byte(8'(b[i]), 1'b1);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(pack(b[3*i], b[3*i+1], b[3*i+2]));
    rand_rdy = 1'b0;
    pixel_ready = 1'b1;
    tick(8);
    pixel_ready = 1'b0;
    n_cmp++; if (n_ovf != 0) begin n_err++; $display("FAIL rand_overflow: got %0d want 0", n_ovf); end
    n_cmp++; if (acc_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d want %0d", acc_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++; if (acc_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_data_%0d: got %h want %h", i, acc_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    RX = 1'b1;
    pixel_ready = 1'b0;
    test_reset();
    test_single_pixel();
    test_overflow();
    test_framing();
    test_gap();
    test_glitch_and_reset();
    test_full_push_pop();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
